// File: rtl/pwm_capture_mode_pkg.sv
// Shared PWM definitions: capture FSM state encoding and the default
// input synchronizer depth used by all PWM input blocks.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } cap_state_e;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/pwm_capture_mode_if.sv
// Capture control and result signals; master drives enable/pwm and reads
// the measurement results, slave is the capture block itself.
interface pwm_capture_mode_if #(
    parameter int unsigned Resolution = 16
);
    logic                  enable_i;
    logic                  pwm_i;
    logic [Resolution-1:0] high_count_o;
    logic [Resolution-1:0] period_count_o;
    logic                  valid_o;
    logic                  overflow_o;
    logic                  level_o;

    modport master (
        output enable_i, pwm_i,
        input  high_count_o, period_count_o, valid_o, overflow_o, level_o
    );

    modport slave (
        input  enable_i, pwm_i,
        output high_count_o, period_count_o, valid_o, overflow_o, level_o
    );
endinterface

// File: rtl/pwm_capture_mode_input_sync.sv
// Multi-flop synchronizer for an asynchronous input plus single-cycle
// rise/fall detection on the synchronized level.
module pwm_input_sync
    import pwm_pkg::*;
#(
    parameter int unsigned SyncStages = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], async_i};
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign level_o = sync_q[SyncStages-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/pwm_capture_mode.sv
// PWM input capture: measures high time and period of pwm_i in clk_i cycles
// between consecutive rising edges, with saturation-based overflow detection.
module pwm_capture_mode
    import pwm_pkg::*;
#(
    parameter int unsigned Resolution = 16,
    parameter int unsigned SyncStages = SYNC_STAGES_DEFAULT
) (
    input logic               clk_i,
    input logic               rst_i,
    pwm_capture_mode_if.slave cap
);
    logic level, rise, fall;

    pwm_input_sync #(.SyncStages(SyncStages)) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cap.pwm_i),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    cap_state_e            state_q, state_d;
    logic [Resolution-1:0] cnt_q, cnt_d;
    logic [Resolution-1:0] hi_tmp_q, hi_tmp_d;
    logic [Resolution-1:0] high_q, high_d;
    logic [Resolution-1:0] period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  cnt_sat;

    assign cnt_sat = &cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_tmp_q <= hi_tmp_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_sat ? cnt_q : cnt_q + 1'b1;
        hi_tmp_d = hi_tmp_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;
        if (rise) begin
            cnt_d = Resolution'(1);
        end

        if (!cap.enable_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hi_tmp_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) state_d = HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        hi_tmp_d = cnt_q;
                        state_d  = LOW;
                    end else if (!rise && cnt_sat) begin
                        ovf_d   = 1'b1;
                        state_d = ARM;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hi_tmp_q;
                        valid_d  = 1'b1;
                        state_d  = HIGH;
                    end else if (!fall && cnt_sat) begin
                        ovf_d   = 1'b1;
                        state_d = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cap.high_count_o   = high_q;
    assign cap.period_count_o = period_q;
    assign cap.valid_o        = valid_q;
    assign cap.overflow_o     = ovf_q;
    assign cap.level_o        = level;
endmodule
